// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the core (master) and the multiply/divide unit (slave).
interface muldiv_if #(
   parameter int unsigned XLEN = 32
);
   logic            start_i;
   logic [2:0]      funct3_i;
   logic [XLEN-1:0] rs1_data_i;
   logic [XLEN-1:0] rs2_data_i;
   logic [4:0]      rd_addr_i;
   logic            busy_o;
   logic            done_o;
   logic            wr_en_o;
   logic [4:0]      rd_addr_o;
   logic [XLEN-1:0] result_o;
   logic            illegal_o;

   modport master (
      output start_i, funct3_i, rs1_data_i, rs2_data_i, rd_addr_i,
      input  busy_o, done_o, wr_en_o, rd_addr_o, result_o, illegal_o
   );

   modport slave (
      input  start_i, funct3_i, rs1_data_i, rs2_data_i, rd_addr_i,
      output busy_o, done_o, wr_en_o, rd_addr_o, result_o, illegal_o
   );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M unit, shift-add multiply and restoring divide, one bit per cycle.
// Define MULDIV_DIV_EN to build the divide datapath; otherwise DIV/REM complete at once as illegal.
module muldiv_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic    clk,
   input  logic    rst,
   muldiv_if.slave bus
);
   localparam int unsigned   CW       = $clog2(XLEN);
   localparam int unsigned   RW       = 5;
   localparam logic [CW-1:0] CNT_INIT = CW'(XLEN - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic [RW-1:0]     rd_q, rd_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              fin_q, fin_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              wr_en_q, wr_en_d;
   logic              illegal_q, illegal_d;

   // Accept-time operand decode: signedness per op, magnitudes for the unsigned datapath
   logic [2:0]      f_i;
   logic            a_sgn, b_sgn, a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;

   assign f_i   = bus.funct3_i;
   assign a_sgn = f_i[2] ? ~f_i[0] : (f_i[1:0] != 2'b11);
   assign b_sgn = f_i[2] ? ~f_i[0] : ~f_i[1];
   assign a_neg = a_sgn & bus.rs1_data_i[XLEN-1];
   assign b_neg = b_sgn & bus.rs2_data_i[XLEN-1];
   assign a_mag = a_neg ? -bus.rs1_data_i : bus.rs1_data_i;
   assign b_mag = b_neg ? -bus.rs2_data_i : bus.rs2_data_i;

   // Multiply step: acc = {partial product, remaining multiplier bits}
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next, prod;
   logic [XLEN-1:0]   mul_res;

   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
   assign prod     = neg_q ? -acc_q : acc_q;
   assign mul_res  = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

`ifdef MULDIV_DIV_EN
   // Divide step: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}
   logic              div_q, div_d;
   logic [XLEN:0]     rem_sh;
   logic [XLEN+1:0]   div_diff;
   logic [2*XLEN-1:0] div_next;
   logic [XLEN-1:0]   quo_f, rem_f, div_res;
   logic              div_zero, div_ovf;
   logic [XLEN-1:0]   spec_res;

   assign rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
   assign div_diff = {1'b0, rem_sh} - {2'b00, opnd_q};
   assign div_next = div_diff[XLEN+1] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
   assign quo_f    = acc_q[XLEN-1:0];
   assign rem_f    = acc_q[2*XLEN-1:XLEN];
   assign div_res  = op_q[1] ? (neg_q ? -rem_f : rem_f) : (neg_q ? -quo_f : quo_f);

   // Overflow quotient equals the dividend itself (most negative value)
   assign div_zero = (bus.rs2_data_i == '0);
   assign div_ovf  = ~f_i[0] & (bus.rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) & (bus.rs2_data_i == '1);
   assign spec_res = div_zero ? (f_i[1] ? bus.rs1_data_i : '1)
                              : (f_i[1] ? '0 : bus.rs1_data_i);
`endif

   // Next-state and registered-output logic
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      rd_d      = rd_q;
      cnt_d     = cnt_q;
      fin_d     = fin_q;
      neg_d     = neg_q;
      opnd_d    = opnd_q;
      acc_d     = acc_q;
      result_d  = result_q;
      done_d    = 1'b0;
      wr_en_d   = 1'b0;
      illegal_d = 1'b0;
`ifdef MULDIV_DIV_EN
      div_d     = div_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start_i) begin
               op_d  = f_i[1:0];
               rd_d  = bus.rd_addr_i;
               cnt_d = CNT_INIT;
               fin_d = 1'b0;
               if (f_i[2]) begin
`ifdef MULDIV_DIV_EN
                  div_d  = 1'b1;
                  neg_d  = f_i[1] ? a_neg : (a_neg ^ b_neg);
                  opnd_d = b_mag;
                  acc_d  = {{XLEN{1'b0}}, a_mag};
                  if (div_zero | div_ovf) begin
                     state_d  = S_DONE;
                     result_d = spec_res;
                     done_d   = 1'b1;
                     wr_en_d  = (bus.rd_addr_i != '0);
                  end else begin
                     state_d = S_RUN;
                  end
`else
                  state_d   = S_DONE;
                  result_d  = '0;
                  done_d    = 1'b1;
                  illegal_d = 1'b1;
`endif
               end else begin
`ifdef MULDIV_DIV_EN
                  div_d = 1'b0;
`endif
                  neg_d   = a_neg ^ b_neg;
                  opnd_d  = a_mag;
                  acc_d   = {{XLEN{1'b0}}, b_mag};
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (fin_q) begin
               state_d  = S_DONE;
               fin_d    = 1'b0;
`ifdef MULDIV_DIV_EN
               result_d = div_q ? div_res : mul_res;
`else
               result_d = mul_res;
`endif
               done_d   = 1'b1;
               wr_en_d  = (rd_q != '0);
            end else begin
`ifdef MULDIV_DIV_EN
               acc_d = div_q ? div_next : mul_next;
`else
               acc_d = mul_next;
`endif
               if (cnt_q == '0) fin_d = 1'b1;
               else             cnt_d = cnt_q - CW'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         rd_q      <= '0;
         cnt_q     <= '0;
         fin_q     <= 1'b0;
         neg_q     <= 1'b0;
         opnd_q    <= '0;
         acc_q     <= '0;
         result_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wr_en_q   <= 1'b0;
         illegal_q <= 1'b0;
`ifdef MULDIV_DIV_EN
         div_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         rd_q      <= rd_d;
         cnt_q     <= cnt_d;
         fin_q     <= fin_d;
         neg_q     <= neg_d;
         opnd_q    <= opnd_d;
         acc_q     <= acc_d;
         result_q  <= result_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         wr_en_q   <= wr_en_d;
         illegal_q <= illegal_d;
`ifdef MULDIV_DIV_EN
         div_q     <= div_d;
`endif
      end
   end

   assign bus.busy_o    = busy_q;
   assign bus.done_o    = done_q;
   assign bus.wr_en_o   = wr_en_q;
   assign bus.rd_addr_o = rd_q;
   assign bus.result_o  = result_q;
   assign bus.illegal_o = illegal_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with literal expectations plus a cycle-level reference model.
module tb_muldiv_unit;
   logic clk = 1'b0;
   logic rst;

   muldiv_if bus ();
   muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic straight from the RV32M definitions
   function automatic void ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output bit ill, output bit spec);
      logic [63:0] sa, sb, ua, ub, p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'b0, a};
      ub = {32'b0, b};
      ill = 1'b0;
      spec = 1'b0;
      r = '0;
      case (f)
         3'b000: begin p = sa * sb; r = p[31:0];  end
         3'b001: begin p = sa * sb; r = p[63:32]; end
         3'b010: begin p = sa * ub; r = p[63:32]; end
         3'b011: begin p = ua * ub; r = p[63:32]; end
`ifdef MULDIV_DIV_EN
         3'b100: begin
            if (b == 0) begin r = 32'hFFFFFFFF; spec = 1'b1; end
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin r = 32'h80000000; spec = 1'b1; end
            else r = 32'($signed(a) / $signed(b));
         end
         3'b101: begin
            if (b == 0) begin r = 32'hFFFFFFFF; spec = 1'b1; end
            else r = a / b;
         end
         3'b110: begin
            if (b == 0) begin r = a; spec = 1'b1; end
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin r = 0; spec = 1'b1; end
            else r = 32'($signed(a) % $signed(b));
         end
         default: begin
            if (b == 0) begin r = a; spec = 1'b1; end
            else r = a % b;
         end
`else
         default: begin r = 0; ill = 1'b1; spec = 1'b1; end
`endif
      endcase
   endfunction

   // Cycle-level model: cycles elapsed since the accept edge, and what the outputs must hold
   bit          m_act = 1'b0;
   int          m_cnt = 0;
   int          m_done_at = 0;
   bit          m_ill = 1'b0;
   bit          chk_en = 1'b0;
   logic [31:0] m_res = '0;
   logic [31:0] m_hold_res = '0;
   logic [4:0]  m_hold_rd = '0;

   always @(posedge clk) begin
      bit spec;
      if (rst) begin
         m_act = 1'b0; m_cnt = 0; m_ill = 1'b0;
         m_hold_res = '0; m_hold_rd = '0;
         chk_en = 1'b1;
      end else if (m_act) begin
         if (m_cnt == m_done_at) m_act = 1'b0;
         else begin
            m_cnt++;
            if (m_cnt == m_done_at) m_hold_res = m_res;
         end
      end else if (bus.start_i) begin
         ref_op(bus.funct3_i, bus.rs1_data_i, bus.rs2_data_i, m_res, m_ill, spec);
         m_act = 1'b1;
         m_cnt = 0;
         m_done_at = spec ? 0 : 33;
         m_hold_rd = bus.rd_addr_i;
         if (spec) m_hold_res = m_res;
      end
   end

   always @(negedge clk) begin
      bit e_done;
      if (chk_en) begin
         e_done = m_act && (m_cnt == m_done_at);
         chk("m_busy",    32'(bus.busy_o),    32'(m_act));
         chk("m_done",    32'(bus.done_o),    32'(e_done));
         chk("m_wr_en",   32'(bus.wr_en_o),   32'(e_done && m_hold_rd != 0 && !m_ill));
         chk("m_illegal", 32'(bus.illegal_o), 32'(e_done && m_ill));
         chk("m_rd_addr", 32'(bus.rd_addr_o), 32'(m_hold_rd));
         chk("m_result",  bus.result_o,       m_hold_res);
      end
   end

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
      int          dn_at;
   } vec_t;

   function automatic vec_t mk(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic [31:0] exp, input int dn_at);
      vec_t v;
      v.f = f; v.a = a; v.b = b; v.rd = rd; v.exp = exp; v.dn_at = dn_at;
      return v;
   endfunction

   // Issue one op at a negedge with the unit idle; returns at a negedge with the unit idle again
   task automatic run_op(input vec_t v, input int repulse_at, input int rst_at);
      logic [31:0] ex;
      int          ee;
      bit          ill;
      bit          seen;
      ex = v.exp; ee = v.dn_at; ill = 1'b0; seen = 1'b0;
`ifndef MULDIV_DIV_EN
      if (v.f[2]) begin ex = 0; ee = 0; ill = 1'b1; end
`endif
      bus.start_i = 1'b1;
      bus.funct3_i = v.f;
      bus.rs1_data_i = v.a;
      bus.rs2_data_i = v.b;
      bus.rd_addr_i = v.rd;
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      bus.funct3_i = 3'($urandom());
      bus.rs1_data_i = $urandom();
      bus.rs2_data_i = $urandom();
      bus.rd_addr_i = 5'($urandom());
      for (int k = 0; k <= 40; k++) begin
         @(negedge clk);
         bus.start_i = 1'b0;
         if (rst_at >= 0 && k == rst_at + 1) begin
            rst = 1'b0;
            chk("rst_busy",    32'(bus.busy_o),    0);
            chk("rst_done",    32'(bus.done_o),    0);
            chk("rst_wr_en",   32'(bus.wr_en_o),   0);
            chk("rst_rd_addr", 32'(bus.rd_addr_o), 0);
            chk("rst_result",  bus.result_o,       0);
            return;
         end
         if (seen) begin
            chk("idle_after_done", 32'(bus.busy_o), 0);
            return;
         end
         if (bus.done_o) begin
            seen = 1'b1;
            chk("latency", 32'(k), 32'(ee));
            chk("result",  bus.result_o, ex);
            chk("wr_en",   32'(bus.wr_en_o), 32'(v.rd != 0 && !ill));
            chk("illegal", 32'(bus.illegal_o), 32'(ill));
            chk("rd_addr", 32'(bus.rd_addr_o), 32'(v.rd));
         end
         if (k == repulse_at) begin
            bus.start_i = 1'b1;
            bus.funct3_i = 3'b000;
         end
         if (k == rst_at) rst = 1'b1;
      end
      chk("done_seen", 32'(seen), 1);
   endtask

   initial begin
      rst = 1'b1;
      bus.start_i = 1'b0;
      bus.funct3_i = '0;
      bus.rs1_data_i = '0;
      bus.rs2_data_i = '0;
      bus.rd_addr_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("init_busy",    32'(bus.busy_o),    0);
      chk("init_done",    32'(bus.done_o),    0);
      chk("init_illegal", 32'(bus.illegal_o), 0);
      chk("init_result",  bus.result_o,       0);
      rst = 1'b0;

      run_op(mk(3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33), -1, -1);
      run_op(mk(3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 33), -1, -1);
      run_op(mk(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 33), -1, -1);
      run_op(mk(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 33), -1, -1);
      run_op(mk(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,  32'h00000001, 33), -1, -1);
      run_op(mk(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, 0),  -1, -1);
      run_op(mk(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h00000000, 0),  -1, -1);
      run_op(mk(3'b101, 32'd5,        32'd0,        5'd12, 32'hFFFFFFFF, 0),  -1, -1);
      run_op(mk(3'b111, 32'd5,        32'd0,        5'd13, 32'h00000005, 0),  -1, -1);
      run_op(mk(3'b110, 32'hFFFFFFF9, 32'd2,        5'd14, 32'hFFFFFFFF, 33), -1, -1);
      run_op(mk(3'b100, 32'hFFFFFFF9, 32'd2,        5'd15, 32'hFFFFFFFD, 33), -1, -1);
      run_op(mk(3'b101, 32'd100,      32'd7,        5'd16, 32'd14,       33), -1, -1);
      run_op(mk(3'b111, 32'd100,      32'd7,        5'd17, 32'd2,        33), -1, -1);
      run_op(mk(3'b100, 32'd100,      32'hFFFFFFF9, 5'd18, 32'hFFFFFFF2, 33), -1, -1);
      run_op(mk(3'b110, 32'd100,      32'hFFFFFFF9, 5'd19, 32'd2,        33), -1, -1);
      run_op(mk(3'b100, 32'hFFFFFFFB, 32'd0,        5'd20, 32'hFFFFFFFF, 0),  -1, -1);
      run_op(mk(3'b110, 32'hFFFFFFFB, 32'd0,        5'd21, 32'hFFFFFFFB, 0),  -1, -1);
      run_op(mk(3'b000, 32'd3,        32'd4,        5'd0,  32'd12,       33), -1, -1);
      run_op(mk(3'b000, 32'h12345678, 32'h10,       5'd22, 32'h23456780, 33), 10, -1);
`ifdef MULDIV_DIV_EN
      run_op(mk(3'b101, 32'd1000,     32'd3,        5'd23, 32'd333,      33), -1, 20);
`else
      run_op(mk(3'b011, 32'd1000,     32'd3,        5'd23, 32'd0,        33), -1, 20);
`endif
      run_op(mk(3'b011, 32'hFFFFFFFF, 32'd2,        5'd4,  32'h00000001, 33), -1, -1);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
